// File: rtl/accel_buf_pkg.sv
// Types and default geometry shared by the ring buffer and its scheduler.
package accel_buf_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_DATA_OF_SET = 128;
    localparam int DEF_DEPTH       = 8;
    localparam int DEF_BURST_LEN   = 4;

    typedef logic [DEF_DATA_OF_SET-1:0][DEF_DATA_WIDTH-1:0] set_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        STREAM = 2'd2
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant, search starts at a registered
// pointer that moves one past the last winner.
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic             found;

    always_comb begin
        int               pos;
        logic [IDX_W-1:0] sel;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = 0;
        sel     = '0;
        if (enable) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                pos = int'(ptr_q) + k;
                if (pos >= NUM_REQ) pos = pos - NUM_REQ;
                sel = IDX_W'(pos);
                if (!found && req[sel]) begin
                    found    = 1'b1;
                    gnt[sel] = 1'b1;
                    gnt_idx  = sel;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/ring_buffer_sched.sv
// Write arbitration and burst drain scheduling for the wide-set ring buffer.
// Tracks its own occupancy so gating never depends on the buffer's flags.
//
//   state  | meaning
//   IDLE   | no burst requested
//   ARMED  | burst requested, waiting for BURST_LEN entries
//   STREAM | presenting beats to the PE array
module ring_buffer_sched
    import accel_buf_pkg::*;
#(
    parameter int  NUM_REQ     = DEF_NUM_REQ,
    parameter int  DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int  DATA_OF_SET = DEF_DATA_OF_SET,
    parameter int  DEPTH       = DEF_DEPTH,
    parameter int  BURST_LEN   = DEF_BURST_LEN,
    localparam int OCC_W       = $clog2(DEPTH + 1)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_REQ-1:0]                            req,
    input  logic [NUM_REQ-1:0][DATA_OF_SET-1:0][DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                            gnt,
    output logic                                          buf_wen,
    output logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0]        buf_din,
    output logic                                          buf_ren,
    input  logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0]        buf_dout,
    input  logic                                          start,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0]        out_data,
    output logic                                          out_last,
    output logic [OCC_W-1:0]                              occupancy,
    output logic                                          busy
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0]  OCC_BURST = OCC_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    sched_state_e      state, state_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt;
    logic [OCC_W-1:0]  occ;
    logic              arb_en;
    logic [IDX_W-1:0]  sel_idx;

    // Full blocks writes even when a read retires the same cycle, keeping
    // out_ready off the grant path. Reset also forces the grant low at once.
    assign arb_en = ~rst & (occ != OCC_FULL);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .enable  (arb_en),
        .gnt     (gnt),
        .gnt_idx (sel_idx)
    );

    assign buf_wen   = |gnt;
    assign buf_din   = req_data[sel_idx];
    assign out_data  = buf_dout;
    assign occupancy = occ;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else if (buf_wen && !buf_ren) begin
            occ <= occ + 1'b1;
        end else if (buf_ren && !buf_wen) begin
            occ <= occ - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        out_valid = 1'b0;
        out_last  = 1'b0;
        buf_ren   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ARMED;
            end
            ARMED: begin
                beat_nxt = '0;
                if (occ >= OCC_BURST) state_nxt = STREAM;
            end
            STREAM: begin
                out_valid = 1'b1;
                out_last  = (beat == BEAT_LAST);
                buf_ren   = out_ready;
                if (out_ready) begin
                    if (out_last) begin
                        state_nxt = IDLE;
                        beat_nxt  = '0;
                    end else begin
                        beat_nxt = beat + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                beat_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ring_buffer_sched.sv
// Bench for ring_buffer_sched: emulated FWFT ring buffer, queue-based
// reference model, randomized producers/readiness.
module tb_ring_buffer_sched;
    import accel_buf_pkg::*;

    localparam int NR    = DEF_NUM_REQ;
    localparam int DEPTH = DEF_DEPTH;
    localparam int BL    = DEF_BURST_LEN;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req;
    set_t [NR-1:0]    req_data;
    logic [NR-1:0]    gnt;
    logic             buf_wen, buf_ren;
    set_t             buf_din, buf_dout, out_data;
    logic             start, out_valid, out_ready, out_last, busy;
    logic [OCC_W-1:0] occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    ring_buffer_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .buf_wen   (buf_wen),
        .buf_din   (buf_din),
        .buf_ren   (buf_ren),
        .buf_dout  (buf_dout),
        .start     (start),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .occupancy (occupancy),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // emulated ring buffer, first-word-fall-through
    set_t mem [DEPTH];
    int   wp, rp;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= 0;
            rp <= 0;
        end else begin
            if (buf_wen) begin
                mem[wp] <= buf_din;
                wp      <= (wp + 1) % DEPTH;
            end
            if (buf_ren) rp <= (rp + 1) % DEPTH;
        end
    end
    assign buf_dout = mem[rp];

    // reference model: phase 0 idle, 1 waiting for data, 2 streaming
    int      m_ptr, m_occ, m_phase, m_beat;
    set_t    sb[$];
    int      e_idx;
    logic [NR-1:0] e_gnt;
    logic    e_valid, e_last, e_busy;
    set_t    e_data;

    function automatic void model_expect();
        e_idx = -1;
        if (m_occ < DEPTH) begin
            for (int k = 0; k < NR; k++) begin
                int i = (m_ptr + k) % NR;
                if (e_idx < 0 && req[i]) e_idx = i;
            end
        end
        e_gnt   = (e_idx >= 0) ? (NR'(1) << e_idx) : '0;
        e_valid = (m_phase == 2);
        e_last  = e_valid && (m_beat == BL - 1);
        e_busy  = (m_phase != 0);
        e_data  = (e_valid && sb.size() > 0) ? sb[0] : '0;
    endfunction

    function automatic void model_commit();
        int occ_before = m_occ;
        logic rd = e_valid && out_ready;
        if (rd) void'(sb.pop_front());
        if (e_idx >= 0) begin
            sb.push_back(req_data[e_idx]);
            m_ptr = (e_idx + 1) % NR;
        end
        m_occ = m_occ + ((e_idx >= 0) ? 1 : 0) - (rd ? 1 : 0);
        case (m_phase)
            0: if (start) m_phase = 1;
            1: if (occ_before >= BL) begin m_phase = 2; m_beat = 0; end
            2: if (rd) begin
                   if (m_beat == BL - 1) m_phase = 0;
                   else m_beat = m_beat + 1;
               end
            default: m_phase = 0;
        endcase
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_occ = 0; m_phase = 0; m_beat = 0;
        sb.delete();
    endtask

    task automatic rand_data();
        for (int i = 0; i < NR; i++)
            for (int w = 0; w < DEF_DATA_OF_SET; w++)
                req_data[i][w] = $urandom;
    endtask

    task automatic sample();
        @(negedge clk);
        model_expect();
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; start = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '1; start = 1'b1; out_ready = 1'b1;
        rand_data();
        #7;
        n_checks++; if (gnt !== '0) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
        n_checks++; if (buf_wen !== 1'b0 || buf_ren !== 1'b0) begin n_fail++; $display("FAIL reset_wen_ren got=%b%b exp=00", buf_wen, buf_ren); end
        n_checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin n_fail++; $display("FAIL reset_valid_last got=%b%b exp=00", out_valid, out_last); end
        n_checks++; if (occupancy !== '0) begin n_fail++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; req = '0; out_ready = 1'b0;
        model_reset();
    endtask

    task automatic test_fill_rr();
        do_reset();
        req = '1;
        for (int c = 0; c < 10; c++) begin
            logic [NR-1:0] want;
            rand_data();
            sample();
            want = (c < 8) ? (NR'(1) << (c % NR)) : '0;
            n_checks++; if (gnt !== want) begin n_fail++; $display("FAIL fill_gnt cyc=%0d got=%b exp=%b", c, gnt, want); end
            n_checks++; if (buf_wen !== (c < 8)) begin n_fail++; $display("FAIL fill_wen cyc=%0d got=%b", c, buf_wen); end
            if (c < 8) begin
                n_checks++; if (buf_din !== req_data[c % NR]) begin n_fail++; $display("FAIL fill_din cyc=%0d got=%h exp=%h", c, buf_din[0], req_data[c % NR][0]); end
            end
            n_checks++; if (occupancy !== OCC_W'((c < 8) ? c : 8)) begin n_fail++; $display("FAIL fill_occ cyc=%0d got=%0d", c, occupancy); end
            tick();
        end
    endtask

    task automatic test_rr_order();
        logic [NR-1:0] pat  [3] = '{4'b0100, 4'b1001, 4'b0001};
        logic [NR-1:0] want [3] = '{4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            req = pat[c];
            rand_data();
            sample();
            n_checks++; if (gnt !== want[c]) begin n_fail++; $display("FAIL rr_gnt step=%0d got=%b exp=%b", c, gnt, want[c]); end
            n_checks++; if (buf_din !== req_data[e_idx]) begin n_fail++; $display("FAIL rr_din step=%0d got=%h exp=%h", c, buf_din[0], req_data[e_idx][0]); end
            tick();
        end
        req = '0;
        sample();
        n_checks++; if (occupancy !== OCC_W'(3)) begin n_fail++; $display("FAIL rr_occ got=%0d exp=3", occupancy); end
        tick();
    endtask

    task automatic test_burst();
        int acc = 0;
        do_reset();
        for (int g = 0; g < 20 && m_occ < 5; g++) begin
            req = NR'($urandom_range(1, (1 << NR) - 1));
            rand_data();
            sample();
            tick();
        end
        req = '0; start = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            sample();
            n_checks++; if (out_valid !== e_valid || out_last !== e_last) begin n_fail++; $display("FAIL burst_vl cyc=%0d got=%b%b exp=%b%b", c, out_valid, out_last, e_valid, e_last); end
            n_checks++; if (busy !== e_busy) begin n_fail++; $display("FAIL burst_busy cyc=%0d got=%b exp=%b", c, busy, e_busy); end
            n_checks++; if (occupancy !== OCC_W'(m_occ)) begin n_fail++; $display("FAIL burst_occ cyc=%0d got=%0d exp=%0d", c, occupancy, m_occ); end
            if (e_valid) begin
                n_checks++; if (out_data !== e_data) begin n_fail++; $display("FAIL burst_data cyc=%0d got=%h exp=%h", c, out_data[0], e_data[0]); end
            end
            if (out_valid && out_ready) acc++;
            tick();
            start = 1'b0;
        end
        n_checks++; if (acc !== 4) begin n_fail++; $display("FAIL burst_beats got=%0d exp=4", acc); end
        n_checks++; if (occupancy !== OCC_W'(1) || busy !== 1'b0) begin n_fail++; $display("FAIL burst_end occ=%0d busy=%b exp=1,0", occupancy, busy); end
    endtask

    task automatic test_armed_wait();
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 2; c++) begin rand_data(); sample(); tick(); end
        req = '0; start = 1'b1; out_ready = 1'b1;
        sample(); tick();
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            req = (c < 2) ? 4'b0010 : 4'b0000;
            rand_data();
            sample();
            n_checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL armed_hold cyc=%0d valid=%b busy=%b exp=0,1", c, out_valid, busy); end
            tick();
            if (c == 2) break;
        end
        for (int c = 0; c < 8; c++) begin
            start = (c == 2);
            sample();
            n_checks++; if (out_valid !== e_valid || out_last !== e_last || busy !== e_busy) begin n_fail++; $display("FAIL armed_stream cyc=%0d got=%b%b%b exp=%b%b%b", c, out_valid, out_last, busy, e_valid, e_last, e_busy); end
            if (e_valid) begin
                n_checks++; if (out_data !== e_data) begin n_fail++; $display("FAIL armed_data cyc=%0d got=%h exp=%h", c, out_data[0], e_data[0]); end
            end
            tick();
        end
        start = 1'b0;
        n_checks++; if (busy !== 1'b0 || occupancy !== '0) begin n_fail++; $display("FAIL armed_restart busy=%b occ=%0d exp=0,0", busy, occupancy); end
    endtask

    task automatic test_ready_toggle();
        int   pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        int   acc = 0;
        logic stalled = 1'b0;
        set_t held;
        do_reset();
        for (int g = 0; g < 20 && m_occ < 5; g++) begin
            req = NR'($urandom_range(1, (1 << NR) - 1));
            rand_data(); sample(); tick();
        end
        req = '0; start = 1'b1;
        sample(); tick();
        start = 1'b0;
        sample(); tick();
        for (int p = 0; p < 7; p++) begin
            out_ready = pat[p][0];
            req = NR'($urandom_range(0, (1 << NR) - 1));
            rand_data();
            sample();
            n_checks++; if (out_valid !== e_valid || out_last !== e_last) begin n_fail++; $display("FAIL toggle_vl p=%0d got=%b%b exp=%b%b", p, out_valid, out_last, e_valid, e_last); end
            n_checks++; if (gnt !== e_gnt || occupancy !== OCC_W'(m_occ)) begin n_fail++; $display("FAIL toggle_wr p=%0d gnt=%b occ=%0d exp=%b,%0d", p, gnt, occupancy, e_gnt, m_occ); end
            if (e_valid) begin
                n_checks++; if (out_data !== e_data) begin n_fail++; $display("FAIL toggle_data p=%0d got=%h exp=%h", p, out_data[0], e_data[0]); end
            end
            if (stalled) begin
                n_checks++; if (out_valid !== 1'b1 || out_data !== held) begin n_fail++; $display("FAIL toggle_stable p=%0d valid=%b got=%h exp=%h", p, out_valid, out_data[0], held[0]); end
            end
            stalled = e_valid && !out_ready;
            held    = e_data;
            if (out_valid && out_ready) acc++;
            tick();
        end
        out_ready = 1'b0; req = '0;
        sample();
        n_checks++; if (acc !== 4 || busy !== 1'b0) begin n_fail++; $display("FAIL toggle_beats got=%0d busy=%b exp=4,0", acc, busy); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            req       = NR'($urandom_range(0, (1 << NR) - 1));
            start     = ($urandom_range(0, 7) == 0);
            out_ready = $urandom_range(0, 1) == 1;
            rand_data();
            sample();
            n_checks++; if (gnt !== e_gnt || buf_wen !== (e_idx >= 0)) begin n_fail++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", c, gnt, e_gnt); end
            n_checks++; if (occupancy !== OCC_W'(m_occ)) begin n_fail++; $display("FAIL rand_occ cyc=%0d got=%0d exp=%0d", c, occupancy, m_occ); end
            n_checks++; if (out_valid !== e_valid || out_last !== e_last || busy !== e_busy) begin n_fail++; $display("FAIL rand_ctl cyc=%0d got=%b%b%b exp=%b%b%b", c, out_valid, out_last, busy, e_valid, e_last, e_busy); end
            n_checks++; if (buf_ren !== (e_valid && out_ready)) begin n_fail++; $display("FAIL rand_ren cyc=%0d got=%b", c, buf_ren); end
            if (e_idx >= 0) begin
                n_checks++; if (buf_din !== req_data[e_idx]) begin n_fail++; $display("FAIL rand_din cyc=%0d got=%h exp=%h", c, buf_din[0], req_data[e_idx][0]); end
            end
            if (e_valid) begin
                n_checks++; if (out_data !== e_data) begin n_fail++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, out_data[0], e_data[0]); end
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req = '1;
        for (int c = 0; c < 8; c++) begin rand_data(); sample(); tick(); end
        start = 1'b1;
        sample(); tick();
        start = 1'b0;
        sample(); tick();
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin rand_data(); sample(); tick(); end
        n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre valid=%b busy=%b exp=1,1", out_valid, busy); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (gnt !== '0 || buf_wen !== 1'b0) begin n_fail++; $display("FAIL midrst_gnt got=%b wen=%b exp=0", gnt, buf_wen); end
        n_checks++; if (out_valid !== 1'b0 || buf_ren !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b ren=%b exp=0", out_valid, buf_ren); end
        n_checks++; if (occupancy !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_state occ=%0d busy=%b exp=0,0", occupancy, busy); end
        @(posedge clk);
        #1;
        rst = 1'b0; out_ready = 1'b0;
        model_reset();
        sample();
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL midrst_restart got=%b exp=0001", gnt); end
        tick();
        req = '0;
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; start = 1'b0; out_ready = 1'b0; req_data = '0;
        model_reset();
        test_reset();
        test_fill_rr();
        test_rr_order();
        test_burst();
        test_armed_wait();
        test_ready_toggle();
        test_random();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
